// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM duty sequencer.
package pwm_pkg;

  localparam int NUM_STEPS_DEF = 4;
  localparam int TICK_DIV_DEF  = 256;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DWELL,
    DONE
  } seq_state_e;

  // Dwell of 0 marks the end of the program.
  typedef struct packed {
    logic [7:0] duty;
    logic [7:0] dwell;
  } slot_t;

endpackage

// File: rtl/pwm_tick_prescaler.sv
// Free-running 0..TICK_DIV-1 counter with a one-cycle tick on its last count.
module pwm_tick_prescaler
  import pwm_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q;

  assign tick = en && (cnt_q == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)   cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (en)  cnt_q <= tick ? '0 : cnt_q + CW'(1);
  end

endmodule

// File: rtl/pwm_sequencer.sv
// Duty-cycle program sequencer between the SPI register bank and the PWM peripheral;
// passes the enable masks through and replaces the manual duty while a program runs.
module pwm_sequencer
  import pwm_pkg::*;
#(
  parameter int NUM_STEPS = NUM_STEPS_DEF,
  parameter int TICK_DIV  = TICK_DIV_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [15:0]                  en_reg_out_in,
  input  logic [15:0]                  en_reg_pwm_in,
  input  logic [7:0]                   manual_duty,
  input  logic                         prog_we,
  input  logic [$clog2(NUM_STEPS)-1:0] prog_addr,
  input  logic [7:0]                   prog_duty,
  input  logic [7:0]                   prog_dwell,
  input  logic                         seq_start,
  input  logic                         seq_stop,
  input  logic                         seq_loop,
  output logic [15:0]                  en_reg_out,
  output logic [15:0]                  en_reg_pwm,
  output logic [7:0]                   pwm_duty_cycle,
  output logic                         busy,
  output logic [$clog2(NUM_STEPS)-1:0] step_idx,
  output logic                         done
);

  localparam int SW = $clog2(NUM_STEPS);

  seq_state_e state_q, state_d;
  slot_t      slots_q [NUM_STEPS];
  slot_t      cur;
  logic [7:0] dwell_q;
  logic       tick, last, wrap, go;

  assign cur  = slots_q[step_idx];
  assign go   = seq_start && !seq_stop;
  assign last = tick && (dwell_q == 8'd1);
  assign wrap = (step_idx == SW'(NUM_STEPS - 1));

  pwm_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == LOAD),
    .en    (state_q == DWELL),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go) state_d = LOAD;
      LOAD:    state_d = (cur.dwell == 8'd0) ? DONE : DWELL;
      DWELL:   if (last) state_d = (wrap && !seq_loop) ? DONE : LOAD;
      default: state_d = IDLE;
    endcase
    if (seq_stop && state_q != IDLE) state_d = IDLE;
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // Slot contents are only consumed in LOAD, so writes never disturb a running dwell.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_reg_out     <= '0;
      en_reg_pwm     <= '0;
      pwm_duty_cycle <= '0;
      step_idx       <= '0;
      dwell_q        <= '0;
      for (int i = 0; i < NUM_STEPS; i++) slots_q[i] <= '0;
    end else begin
      en_reg_out <= en_reg_out_in;
      en_reg_pwm <= en_reg_pwm_in;
      if (prog_we) slots_q[prog_addr] <= '{duty: prog_duty, dwell: prog_dwell};
      case (state_q)
        IDLE: begin
          pwm_duty_cycle <= manual_duty;
          if (go) step_idx <= '0;
        end
        LOAD: if (cur.dwell != 8'd0) begin
          dwell_q        <= cur.dwell;
          pwm_duty_cycle <= cur.duty;
        end
        DWELL: begin
          if (tick) dwell_q <= dwell_q - 8'd1;
          // Keep the final index visible through DONE when not looping.
          if (last && !(wrap && !seq_loop)) step_idx <= step_idx + SW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_sequencer.sv
// Bench for pwm_sequencer: cycle model compared every cycle plus directed literal checks.
module tb_pwm_sequencer;

  localparam int NS = 4;
  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] en_reg_out_in, en_reg_pwm_in;
  logic [7:0]  manual_duty;
  logic        prog_we;
  logic [1:0]  prog_addr;
  logic [7:0]  prog_duty, prog_dwell;
  logic        seq_start, seq_stop, seq_loop;
  logic [15:0] en_reg_out, en_reg_pwm;
  logic [7:0]  pwm_duty_cycle;
  logic        busy, done;
  logic [1:0]  step_idx;

  always #5 clk = ~clk;

  pwm_sequencer #(.NUM_STEPS(NS), .TICK_DIV(TD)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en_reg_out_in  (en_reg_out_in),
    .en_reg_pwm_in  (en_reg_pwm_in),
    .manual_duty    (manual_duty),
    .prog_we        (prog_we),
    .prog_addr      (prog_addr),
    .prog_duty      (prog_duty),
    .prog_dwell     (prog_dwell),
    .seq_start      (seq_start),
    .seq_stop       (seq_stop),
    .seq_loop       (seq_loop),
    .en_reg_out     (en_reg_out),
    .en_reg_pwm     (en_reg_pwm),
    .pwm_duty_cycle (pwm_duty_cycle),
    .busy           (busy),
    .step_idx       (step_idx),
    .done           (done)
  );

  int n_chk = 0, n_fail = 0;
  bit chk_en = 0, rec = 0;
  int done_seen = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: phase 0 idle, 1 load, 2 dwell, 3 done; dwell tracked as cycles left.
  int m_phase, m_left, m_step, m_duty, m_eo, m_ep;
  int m_sd [NS];
  int m_sw [NS];

  always @(posedge clk) begin : model
    int np;
    if (!rst_n) begin
      m_phase = 0; m_left = 0; m_step = 0; m_duty = 0; m_eo = 0; m_ep = 0;
      for (int i = 0; i < NS; i++) begin m_sd[i] = 0; m_sw[i] = 0; end
    end else begin
      np   = m_phase;
      m_eo = en_reg_out_in;
      m_ep = en_reg_pwm_in;
      case (m_phase)
        0: begin
          m_duty = manual_duty;
          if (seq_start && !seq_stop) begin np = 1; m_step = 0; end
        end
        1: if (m_sw[m_step] == 0) np = 3;
           else begin m_left = m_sw[m_step] * TD; m_duty = m_sd[m_step]; np = 2; end
        2: begin
          m_left--;
          if (m_left == 0) begin
            if (m_step == NS - 1 && !seq_loop) np = 3;
            else begin m_step = (m_step + 1) % NS; np = 1; end
          end
        end
        default: np = 0;
      endcase
      if (seq_stop && m_phase != 0) np = 0;
      m_phase = np;
      if (prog_we) begin m_sd[prog_addr] = prog_duty; m_sw[prog_addr] = prog_dwell; end
    end
  end

  always @(negedge clk) if (chk_en) begin
    check("cmp_duty",    pwm_duty_cycle, m_duty);
    check("cmp_busy",    busy, m_phase != 0);
    check("cmp_done",    done, m_phase == 3);
    check("cmp_step",    step_idx, m_step);
    check("cmp_en_out",  en_reg_out, m_eo);
    check("cmp_en_pwm",  en_reg_pwm, m_ep);
  end

  typedef struct {
    logic [7:0] duty;
    logic       busy;
    logic       done;
    logic [1:0] step;
  } obs_t;
  obs_t log_q [$];
  int   run_val [$];
  int   run_len [$];

  always @(negedge clk) begin
    if (done === 1'b1) done_seen++;
    if (rec) log_q.push_back('{pwm_duty_cycle, busy, done, step_idx});
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic adv(input int n);
    repeat (n) cyc();
  endtask

  task automatic wr(input int a, input int d, input int w);
    prog_we = 1; prog_addr = 2'(a); prog_duty = 8'(d); prog_dwell = 8'(w);
    cyc();
    prog_we = 0;
  endtask

  initial begin
    int n40, nc0, nd, dd, ds, d0;
    obs_t lst;
    rst_n = 0; prog_we = 0; prog_addr = 0; prog_duty = 0; prog_dwell = 0;
    seq_start = 0; seq_stop = 0; seq_loop = 0; manual_duty = 8'h5C;
    en_reg_out_in = 16'hA5A5; en_reg_pwm_in = 16'h5A5A;
    cyc(); chk_en = 1; adv(2);
    check("rst_duty", pwm_duty_cycle, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_step", step_idx, 0);
    check("rst_en_out", en_reg_out, 0);
    check("rst_en_pwm", en_reg_pwm, 0);
    rst_n = 1;

    // Manual duty passthrough
    manual_duty = 8'h80; en_reg_out_in = 16'h1234; en_reg_pwm_in = 16'h00FF;
    cyc();
    check("man_duty", pwm_duty_cycle, 8'h80);
    check("man_busy", busy, 0);
    check("man_en_out", en_reg_out, 16'h1234);
    check("man_en_pwm", en_reg_pwm, 16'h00FF);

    // Two-step program ending on a terminator
    manual_duty = 8'h11;
    wr(0, 8'h40, 2); wr(1, 8'hC0, 1); wr(2, 0, 0); wr(3, 8'h55, 3);
    log_q.delete(); rec = 1;
    seq_start = 1; cyc(); seq_start = 0; adv(29); rec = 0;
    n40 = 0; nc0 = 0; nd = 0; dd = 0; ds = 0;
    foreach (log_q[i]) begin
      if (log_q[i].duty == 8'h40) n40++;
      if (log_q[i].duty == 8'hC0 && log_q[i].busy && !log_q[i].done) nc0++;
      if (log_q[i].done) begin nd++; dd = log_q[i].duty; ds = log_q[i].step; end
    end
    lst = log_q[log_q.size() - 1];
    check("seq_len_40", n40, 9);
    check("seq_len_c0", nc0, 5);
    check("seq_done_cnt", nd, 1);
    check("seq_done_duty", dd, 8'hC0);
    check("seq_done_step", ds, 2);
    check("seq_end_duty", lst.duty, 8'h11);
    check("seq_end_busy", lst.busy, 0);

    // Looping program, loop dropped during the second pass
    wr(0, 8'h10, 1); wr(1, 8'h20, 1); wr(2, 8'h30, 1); wr(3, 8'h40, 1);
    seq_loop = 1; log_q.delete(); rec = 1;
    seq_start = 1; cyc(); seq_start = 0; adv(24);
    seq_loop = 0; adv(25); rec = 0;
    run_val.delete(); run_len.delete(); nd = 0;
    foreach (log_q[i]) begin
      if (log_q[i].done) nd++;
      if (log_q[i].busy && !log_q[i].done) begin
        if (run_val.size() > 0 && run_val[run_val.size() - 1] == int'(log_q[i].step))
          run_len[run_len.size() - 1]++;
        else begin run_val.push_back(int'(log_q[i].step)); run_len.push_back(1); end
      end
    end
    check("loop_runs", run_len.size(), 8);
    for (int i = 0; i < 8 && i < run_len.size(); i++) begin
      check("loop_step", run_val[i], i % 4);
      check("loop_len", run_len[i], 5);
    end
    check("loop_done_cnt", nd, 1);

    // Stop during step 1 dwell
    manual_duty = 8'h77; d0 = done_seen;
    seq_start = 1; cyc(); seq_start = 0; adv(7);
    check("stop_pre_step", step_idx, 1);
    check("stop_pre_duty", pwm_duty_cycle, 8'h20);
    seq_stop = 1; cyc(); seq_stop = 0;
    check("stop_busy", busy, 0);
    check("stop_done", done, 0);
    cyc();
    check("stop_manual", pwm_duty_cycle, 8'h77);
    check("stop_no_done", done_seen - d0, 0);
    seq_start = 1; seq_stop = 1; cyc(); seq_start = 0; seq_stop = 0;
    check("startstop_busy0", busy, 0);
    cyc();
    check("startstop_busy1", busy, 0);

    // Slot rewrites while running
    seq_loop = 1;
    seq_start = 1; cyc(); seq_start = 0; cyc();
    prog_we = 1; prog_addr = 0; prog_duty = 8'h99; prog_dwell = 1; cyc(); prog_we = 0;
    check("wr_mid_duty", pwm_duty_cycle, 8'h10);
    adv(19);
    check("wr_next_pass", pwm_duty_cycle, 8'h99);
    check("wr_next_step", step_idx, 0);
    adv(4);
    prog_we = 1; prog_addr = 1; prog_duty = 8'hAB; prog_dwell = 1; cyc(); prog_we = 0;
    check("wr_load_old", pwm_duty_cycle, 8'h20);
    adv(20);
    check("wr_load_later", pwm_duty_cycle, 8'hAB);
    seq_stop = 1; cyc(); seq_stop = 0; seq_loop = 0;

    // Reset mid-dwell, then slot 0 is a terminator
    en_reg_out_in = 16'hBEEF; en_reg_pwm_in = 16'hCAFE; manual_duty = 8'h33;
    seq_start = 1; cyc(); seq_start = 0; adv(2);
    check("rr_pre_busy", busy, 1);
    rst_n = 0; cyc();
    check("rr_duty", pwm_duty_cycle, 0);
    check("rr_busy", busy, 0);
    check("rr_done", done, 0);
    check("rr_step", step_idx, 0);
    check("rr_en_out", en_reg_out, 0);
    check("rr_en_pwm", en_reg_pwm, 0);
    rst_n = 1; d0 = done_seen;
    seq_start = 1; cyc(); seq_start = 0;
    check("term_load_busy", busy, 1);
    cyc();
    check("term_done", done, 1);
    cyc();
    check("term_idle_busy", busy, 0);
    check("term_idle_done", done, 0);
    check("term_done_cnt", done_seen - d0, 1);
    adv(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_sequencer.md
PWM_SEQUENCER -- requirements
Module: pwm_sequencer

Interface
REQ-001 SHALL have parameter NUM_STEPS, default 4, number of program slots (power of two, 2..8).
REQ-002 SHALL have parameter TICK_DIV, default 256, clock cycles per dwell tick (>=2).
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port en_reg_out_in  input  16  output-enable mask from the SPI register bank.
REQ-006 SHALL have port en_reg_pwm_in  input  16  PWM-enable mask from the SPI register bank.
REQ-007 SHALL have port manual_duty  input  8  SPI-programmed duty cycle.
REQ-008 SHALL have port prog_we  input  1  program-slot write strobe.
REQ-009 SHALL have port prog_addr  input  log2(NUM_STEPS)  slot index.
REQ-010 SHALL have port prog_duty  input  8  slot duty value.
REQ-011 SHALL have port prog_dwell  input  8  slot dwell in ticks; 0 = terminator.
REQ-012 SHALL have ports seq_start, seq_stop, seq_loop  input  1 each  start pulse, stop pulse, loop-mode level.
REQ-013 SHALL have ports en_reg_out, en_reg_pwm  output  16 each  masks to the PWM peripheral.
REQ-014 SHALL have port pwm_duty_cycle  output  8  duty to the PWM peripheral.
REQ-015 SHALL have ports busy  output  1, step_idx  output  log2(NUM_STEPS), done  output  1 (one-cycle pulse).

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, DWELL, DONE.
REQ-017 SHALL register en_reg_out/en_reg_pwm from their inputs every cycle, 1-cycle latency, in all states.
REQ-018 SHALL, in IDLE, drive pwm_duty_cycle = manual_duty registered (1-cycle latency).
REQ-019 SHALL, on seq_start in IDLE, set step_idx=0 and enter LOAD next cycle; busy=1 in every state except IDLE.
REQ-020 SHALL ignore seq_start outside IDLE.
REQ-021 SHALL, in LOAD, if slot[step_idx].dwell==0 enter DONE; otherwise load dwell counter, clear prescaler, register pwm_duty_cycle=slot duty, and enter DWELL.
REQ-022 SHALL, in DWELL, generate a tick every TICK_DIV cycles (prescaler counts 0..TICK_DIV-1) and decrement the dwell counter on each tick; a step with dwell N SHALL occupy exactly 1 + N*TICK_DIV cycles (LOAD + DWELL).
REQ-023 SHALL, when the dwell counter reaches 0, go to LOAD with step_idx+1, or, when step_idx==NUM_STEPS-1, go to LOAD with step_idx=0 if seq_loop=1 else to DONE.
REQ-024 SHALL sample seq_loop only at the wrap decision.
REQ-025 SHALL, in DONE, assert done for one cycle, hold the last sequenced duty, and return to IDLE (manual duty resumes the cycle after).
REQ-026 SHALL, on seq_stop in any non-IDLE state, enter IDLE next cycle with no done pulse; seq_stop beats a simultaneous seq_start.
REQ-027 SHALL accept prog_we in any state; writes take effect at the next LOAD of that slot, never mid-DWELL.
REQ-028 SHALL, on a prog_we to the slot being read in LOAD in the same cycle, use the old contents.

Reset
REQ-029 SHALL, on rst_n=0 at a clock edge, set state=IDLE, busy=0, done=0, step_idx=0, pwm_duty_cycle=0, en_reg_out=0, en_reg_pwm=0, and prescaler and dwell counter=0.
REQ-030 SHALL clear all program slots to duty 0, dwell 0 on reset.
REQ-031 SHALL abandon a running sequence on reset mid-operation with no done pulse.

Structure
REQ-032 SHALL place the state enumeration and the default NUM_STEPS/TICK_DIV values in the shared package pwm_pkg.
REQ-033 SHALL use one sub-module, pwm_tick_prescaler (counter with clear input and tick output).
REQ-034 SHALL sit between spi_peripheral and pwm_peripheral at the top level.

Verification (TICK_DIV=4, NUM_STEPS=4)
REQ-035 SHALL cover: manual_duty=0x80 in IDLE -> pwm_duty_cycle=0x80 one cycle later, busy=0.
REQ-036 SHALL cover: slots {0x40/2, 0xC0/1, 0x00/0}, start, loop=0 -> duty 0x40 for 9 cycles, 0xC0 for 5 cycles, then LOAD on slot 2, DONE with done=1 for one cycle, then IDLE.
REQ-037 SHALL cover: all four slots dwell=1, loop=1 -> step_idx cycles 0,1,2,3,0 with each step 5 cycles; clearing loop before the wrap gives done after step 3.
REQ-038 SHALL cover: seq_stop in DWELL of step 1 -> IDLE next cycle, no done, manual duty restored one cycle later; start+stop in the same cycle from IDLE -> stays IDLE.
REQ-039 SHALL cover: prog_we to the active slot during DWELL -> current duty unchanged, new value applied on the next loop pass.
REQ-040 SHALL cover: rst_n low mid-DWELL -> all outputs 0 and state IDLE at the next edge, and slot 0 then reads as a terminator (start -> done with no DWELL).
